trig_pulse_gen: RTL and testbench

- Transmit-side counterpart of the rising-edge detectors in the FOFB trigger path.
- Accepts a single-cycle start strobe.
- Waits a programmable delay, then drives a clean level trigger high for a programmable number of cycles.
- Used to generate DAC/ADC trigger levels that downstream blocks convert back to single-cycle pulses.

---
 rtl/trig_pulse_gen_pkg.sv | 13 +
 rtl/trig_pulse_gen_dn_counter.sv | 30 +++
 rtl/trig_pulse_gen.sv | 110 +++++++++++
 tb/tb_trig_pulse_gen.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_pulse_gen_pkg.sv
// Shared definitions for the trigger pulse generator: state encoding and default counter widths.
package trig_pulse_gen_pkg;

  localparam int unsigned DLY_W_DEF = 16;
  localparam int unsigned WID_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_HIGH  = 2'd2
  } state_e;

endpackage

// File: rtl/trig_pulse_gen_dn_counter.sv
// Loadable down counter that stops at zero and flags a terminal count of one.
module trig_pulse_gen_dn_counter
  import trig_pulse_gen_pkg::*;
#(
  parameter int unsigned W = DLY_W_DEF
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc_c
);

  logic [W-1:0] cnt;

  // Load takes priority over counting; the count never wraps below zero.
  always_ff @(posedge clk) begin
    if (Reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc_c = (cnt == W'(1));

endmodule

// File: rtl/trig_pulse_gen.sv
// Start-strobe driven trigger generator: programmable delay, then a level held high
// for a programmable number of cycles, with done/overrun status pulses.
module trig_pulse_gen
  import trig_pulse_gen_pkg::*;
#(
  parameter int unsigned DLY_W = DLY_W_DEF,
  parameter int unsigned WID_W = WID_W_DEF
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [DLY_W-1:0] delay,
  input  logic [WID_W-1:0] width,
  output logic             trig_out,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  state_e           state;
  state_e           state_nxt;
  logic             trig_nxt;
  logic             done_nxt;
  logic             overrun_nxt;
  logic             load;
  logic             dly_tc_c;
  logic             wid_tc_c;
  logic [WID_W-1:0] width_eff_c;

  // A zero width still produces a one-cycle pulse.
  assign width_eff_c = (width == '0) ? WID_W'(1) : width;

  trig_pulse_gen_dn_counter #(.W(DLY_W)) u_dly_cnt (
    .clk      (clk),
    .Reset    (Reset),
    .load     (load),
    .load_val (delay),
    .en       (state == ST_DELAY),
    .tc_c     (dly_tc_c)
  );

  trig_pulse_gen_dn_counter #(.W(WID_W)) u_wid_cnt (
    .clk      (clk),
    .Reset    (Reset),
    .load     (load),
    .load_val (width_eff_c),
    .en       (state == ST_HIGH),
    .tc_c     (wid_tc_c)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      state    <= ST_IDLE;
      trig_out <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_nxt;
      trig_out <= trig_nxt;
      done     <= done_nxt;
      overrun  <= overrun_nxt;
    end
  end

  // Next-state and next-output decode; counters reach 1 on the last cycle of each phase.
  always_comb begin
    state_nxt   = state;
    trig_nxt    = trig_out;
    done_nxt    = 1'b0;
    overrun_nxt = 1'b0;
    load        = 1'b0;
    case (state)
      ST_IDLE: begin
        trig_nxt = 1'b0;
        if (start) begin
          load = 1'b1;
          if (delay == '0) begin
            state_nxt = ST_HIGH;
            trig_nxt  = 1'b1;
          end else begin
            state_nxt = ST_DELAY;
          end
        end
      end
      ST_DELAY: begin
        overrun_nxt = start;
        if (dly_tc_c) begin
          state_nxt = ST_HIGH;
          trig_nxt  = 1'b1;
        end
      end
      ST_HIGH: begin
        overrun_nxt = start;
        trig_nxt    = 1'b1;
        if (wid_tc_c) begin
          state_nxt = ST_IDLE;
          trig_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        trig_nxt  = 1'b0;
      end
    endcase
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_trig_pulse_gen.sv
// Directed bench for trig_pulse_gen: a cycle-indexed schedule model checked every cycle,
// plus literal latency expectations per scenario.
module tb_trig_pulse_gen;

  localparam int unsigned DW = 16;
  localparam int unsigned WW = 16;

  logic          clk = 1'b0;
  logic          Reset = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] delay = '0;
  logic [WW-1:0] width = '0;
  logic          trig_out;
  logic          busy;
  logic          done;
  logic          overrun;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  bit     model_valid = 1'b0;

  // Model: the accepted request (start cycle, D, W) and the cycles of scheduled pulses.
  bit     m_act = 1'b0;
  longint m_s = 0, m_d = 0, m_w = 0;
  longint m_done = -1, m_ovr = -1;
  bit     exp_trig = 1'b0, exp_busy = 1'b0, exp_done = 1'b0, exp_ovr = 1'b0;

  longint rises[$], falls[$], dones[$], ovrs[$];
  longint busy_cnt = 0;
  logic   prev_trig = 1'b0;

  always #5 clk = ~clk;

  trig_pulse_gen #(.DLY_W(DW), .WID_W(WW)) dut (
    .clk      (clk),
    .Reset    (Reset),
    .start    (start),
    .delay    (delay),
    .width    (width),
    .trig_out (trig_out),
    .busy     (busy),
    .done     (done),
    .overrun  (overrun)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic longint at(input longint q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Model: evaluates the inputs of cycle cyc and predicts the outputs of cycle cyc+1.
  initial begin
    longint n;
    bit     busy_now;
    forever begin
      @(posedge clk);
      if (Reset) begin
        m_act = 1'b0;
        m_done = -1;
        m_ovr = -1;
        model_valid = 1'b1;
      end else if (model_valid) begin
        busy_now = m_act && (cyc <= m_s + m_d + m_w);
        if (start && busy_now) begin
          m_ovr = cyc + 1;
        end else if (start) begin
          m_act  = 1'b1;
          m_s    = cyc;
          m_d    = longint'(delay);
          m_w    = (width == '0) ? 1 : longint'(width);
          m_done = m_s + m_d + m_w + 1;
        end
      end
      n = cyc + 1;
      exp_busy = m_act && (n >= m_s + 1) && (n <= m_s + m_d + m_w);
      exp_trig = m_act && (n >= m_s + m_d + 1) && (n <= m_s + m_d + m_w);
      exp_done = (n == m_done);
      exp_ovr  = (n == m_ovr);
      cyc = n;
    end
  end

  // Compare every cycle and log edges/pulses for the literal checks.
  initial begin
    forever begin
      @(negedge clk);
      if (model_valid) begin
        check("trig_out", 64'(trig_out), 64'(exp_trig));
        check("busy",     64'(busy),     64'(exp_busy));
        check("done",     64'(done),     64'(exp_done));
        check("overrun",  64'(overrun),  64'(exp_ovr));
        if (trig_out === 1'b1 && prev_trig !== 1'b1) rises.push_back(cyc);
        if (trig_out === 1'b0 && prev_trig === 1'b1) falls.push_back(cyc);
        if (done === 1'b1) dones.push_back(cyc);
        if (overrun === 1'b1) ovrs.push_back(cyc);
        if (busy === 1'b1) busy_cnt++;
        prev_trig = trig_out;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    rises.delete();
    falls.delete();
    dones.delete();
    ovrs.delete();
    busy_cnt = 0;
  endtask

  // Present a one-cycle start, then scramble delay/width to show they are not relatched.
  task automatic req(input int d, input int w, output longint st);
    start = 1'b1;
    delay = DW'(d);
    width = WW'(w);
    st = cyc;
    tick();
    start = 1'b0;
    delay = DW'($urandom);
    width = WW'($urandom);
  endtask

  initial begin
    longint st, st2;

    repeat (3) tick();
    check("rst_trig", 64'(trig_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ovr",  64'(overrun), 64'd0);
    Reset = 1'b0;
    clear_log();
    repeat (10) tick();
    check("idle_rises", 64'(rises.size()), 64'd0);
    check("idle_busy",  64'(busy_cnt), 64'd0);

    // delay=0, width=1
    clear_log();
    req(0, 1, st);
    repeat (5) tick();
    check("d0w1_rise", 64'(at(rises, 0)), 64'(st + 1));
    check("d0w1_fall", 64'(at(falls, 0)), 64'(st + 2));
    check("d0w1_done", 64'(at(dones, 0)), 64'(st + 2));
    check("d0w1_busy", 64'(busy_cnt), 64'd1);

    // delay=5, width=4, single detected edge
    clear_log();
    req(5, 4, st);
    repeat (14) tick();
    check("d5w4_rise",  64'(at(rises, 0)), 64'(st + 6));
    check("d5w4_edges", 64'(rises.size()), 64'd1);
    check("d5w4_fall",  64'(at(falls, 0)), 64'(st + 10));
    check("d5w4_done",  64'(at(dones, 0)), 64'(st + 10));
    check("d5w4_busy",  64'(busy_cnt), 64'd9);

    // start while busy -> overrun, pulse unaffected
    clear_log();
    req(5, 4, st);
    repeat (3) tick();
    req(0, 9, st2);
    repeat (20) tick();
    check("ovr_at",    64'(at(ovrs, 0)), 64'(st + 5));
    check("ovr_count", 64'(ovrs.size()), 64'd1);
    check("ovr_edges", 64'(rises.size()), 64'd1);
    check("ovr_rise",  64'(at(rises, 0)), 64'(st + 6));
    check("ovr_fall",  64'(at(falls, 0)), 64'(st + 10));

    // back-to-back: second start on the done cycle
    clear_log();
    req(2, 3, st);
    repeat (5) tick();
    req(2, 3, st2);
    repeat (10) tick();
    check("b2b_rise0", 64'(at(rises, 0)), 64'(st + 3));
    check("b2b_fall0", 64'(at(falls, 0)), 64'(st + 6));
    check("b2b_rise1", 64'(at(rises, 1)), 64'(st + 9));
    check("b2b_fall1", 64'(at(falls, 1)), 64'(st + 12));
    check("b2b_ovr",   64'(ovrs.size()), 64'd0);

    // reset during HIGH aborts without done; next request normal
    clear_log();
    req(5, 4, st);
    repeat (6) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    repeat (2) tick();
    check("abort_rise", 64'(at(rises, 0)), 64'(st + 6));
    check("abort_fall", 64'(at(falls, 0)), 64'(st + 8));
    check("abort_done", 64'(dones.size()), 64'd0);
    clear_log();
    req(1, 2, st2);
    repeat (8) tick();
    check("post_rise", 64'(at(rises, 0)), 64'(st2 + 2));
    check("post_fall", 64'(at(falls, 0)), 64'(st2 + 4));
    check("post_done", 64'(at(dones, 0)), 64'(st2 + 4));

    // start together with Reset is dropped
    clear_log();
    Reset = 1'b1;
    req(0, 3, st);
    Reset = 1'b0;
    repeat (6) tick();
    check("rst_start_rises", 64'(rises.size()), 64'd0);
    check("rst_start_busy",  64'(busy_cnt), 64'd0);

    // width=0 behaves as width=1
    clear_log();
    req(3, 0, st);
    repeat (8) tick();
    check("w0_rise", 64'(at(rises, 0)), 64'(st + 4));
    check("w0_fall", 64'(at(falls, 0)), 64'(st + 5));
    check("w0_done", 64'(at(dones, 0)), 64'(st + 5));

    // maximum delay, no wrap
    clear_log();
    req(65535, 2, st);
    repeat (65545) tick();
    check("dmax_rise", 64'(at(rises, 0)), 64'(st + 65536));
    check("dmax_fall", 64'(at(falls, 0)), 64'(st + 65538));
    check("dmax_done", 64'(at(dones, 0)), 64'(st + 65538));
    check("dmax_busy", 64'(busy_cnt), 64'd65537);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
